binary_conv3x3: RTL and testbench

Streaming 3x3 binary convolution stage that sits directly upstream of `max_pooling` in the MNIST datapath. It accepts one binarised pixel per valid cycle in raster order from an `IMG_W` x `IMG_H` frame and slides a 3x3 window across it using two row line buffers. For each complete window it computes an XNOR-popcount against fixed weights, thresholds the result to one bit, and emits a raster stream of `(IMG_W-2)` x `(IMG_H-2)` bits. That stream is the `pixel_in` feed of `max_pooling`.

---
 rtl/mnist_pkg.sv | 17 +
 rtl/binary_conv3x3_line_buffer.sv | 21 ++
 rtl/binary_conv3x3.sv | 78 +++++++
 tb/tb_binary_conv3x3.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mnist_pkg.sv
// Shared MNIST datapath definitions: default frame geometry, counter widths
// and the 9-bit popcount used by the binary convolution.
package mnist_pkg;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  function automatic logic [3:0] popcount9(input logic [8:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int k = 0; k < 9; k++) cnt = cnt + {3'b000, v[k]};
    return cnt;
  endfunction

endpackage

// File: rtl/binary_conv3x3_line_buffer.sv
// DEPTH x 1-bit shift register; dout is the bit written DEPTH enables ago,
// i.e. the same column of the previous row when DEPTH equals the frame width.
module line_buffer #(
  parameter int DEPTH = 28
) (
  input  logic clk,
  input  logic en,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  // Contents are never reset: consumers ignore them until two rows are loaded.
  always_ff @(posedge clk) begin
    if (en) sr <= {sr[DEPTH-2:0], din};
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/binary_conv3x3.sv
// Streaming 3x3 XNOR-popcount convolution over a raster binary frame,
// producing a thresholded (IMG_W-2) x (IMG_H-2) raster bit stream.
module binary_conv3x3
  import mnist_pkg::*;
#(
  parameter int         IMG_W   = mnist_pkg::IMG_W,
  parameter int         IMG_H   = mnist_pkg::IMG_H,
  parameter logic [8:0] WEIGHTS = 9'h1FF,
  parameter int         THRESH  = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pixel_in,
  input  logic valid_in,
  output logic conv_out,
  output logic valid_out_conv,
  output logic frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          lb1_out, lb2_out;
  logic [8:0]    win, win_nxt;
  logic          last_col, last_row, win_done, conv_hit;

  line_buffer #(.DEPTH(IMG_W)) u_lb1 (
    .clk  (clk),
    .en   (valid_in),
    .din  (pixel_in),
    .dout (lb1_out)
  );

  line_buffer #(.DEPTH(IMG_W)) u_lb2 (
    .clk  (clk),
    .en   (valid_in),
    .din  (lb1_out),
    .dout (lb2_out)
  );

  // Bit 3*i+j: each row shifts left and takes the new right-hand column,
  // top row from the older line buffer, bottom row from the live pixel.
  assign win_nxt = {pixel_in, win[8:7], lb1_out, win[5:4], lb2_out, win[2:1]};

  always_ff @(posedge clk) begin
    if (valid_in) win <= win_nxt;
  end

  assign last_col = (col == CW'(IMG_W - 1));
  assign last_row = (row == RW'(IMG_H - 1));
  assign win_done = (row >= RW'(2)) && (col >= CW'(2));
  assign conv_hit = popcount9(~(win_nxt ^ WEIGHTS)) >= 4'(THRESH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col            <= '0;
      row            <= '0;
      conv_out       <= 1'b0;
      valid_out_conv <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      valid_out_conv <= valid_in && win_done;
      frame_done     <= valid_in && last_col && last_row;
      if (valid_in && win_done) conv_out <= conv_hit;
      if (valid_in) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_binary_conv3x3.sv
// Bench for binary_conv3x3: four 5x5 instances with different kernels share
// one pixel stream; each has a scoreboard queue checked on every output pulse.
module tb_binary_conv3x3;

  localparam logic [8:0] WT [4] = '{9'h1FF, 9'h000, 9'h1FF, 9'h1FF};
  localparam int         TH [4] = '{5, 9, 1, 9};

  typedef struct packed {
    logic        v;
    logic        fd;
    logic [31:0] stamp;
  } exp_t;

  typedef struct {
    string       name;
    logic [24:0] frame;
    int          sel;
    logic [8:0]  exp;
    bit          gap;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, pixel_in = 1'b0, valid_in = 1'b0;
  logic [3:0] conv_out, valid_out, frame_done;
  int   cyc = 0;
  int   checks = 0, passed = 0;
  bit   gap_mode = 1'b0;
  logic [3:0] prev_v = '0;
  exp_t q [4][$];
  int   fd_cyc [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  binary_conv3x3 #(.IMG_W(5), .IMG_H(5), .WEIGHTS(9'h1FF), .THRESH(5)) u_a (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .valid_in(valid_in),
    .conv_out(conv_out[0]), .valid_out_conv(valid_out[0]), .frame_done(frame_done[0]));
  binary_conv3x3 #(.IMG_W(5), .IMG_H(5), .WEIGHTS(9'h000), .THRESH(9)) u_b (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .valid_in(valid_in),
    .conv_out(conv_out[1]), .valid_out_conv(valid_out[1]), .frame_done(frame_done[1]));
  binary_conv3x3 #(.IMG_W(5), .IMG_H(5), .WEIGHTS(9'h1FF), .THRESH(1)) u_c (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .valid_in(valid_in),
    .conv_out(conv_out[2]), .valid_out_conv(valid_out[2]), .frame_done(frame_done[2]));
  binary_conv3x3 #(.IMG_W(5), .IMG_H(5), .WEIGHTS(9'h1FF), .THRESH(9)) u_d (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .valid_in(valid_in),
    .conv_out(conv_out[3]), .valid_out_conv(valid_out[3]), .frame_done(frame_done[3]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Direct window evaluation on the frame image for output at input (r,c).
  function automatic logic model(input logic [24:0] f, input int r, input int c, input int d);
    logic [8:0] w;
    int cnt;
    w = WT[d];
    cnt = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (f[(r - 2 + i) * 5 + (c - 2 + j)] == w[3 * i + j]) cnt++;
    return cnt >= TH[d];
  endfunction

  task automatic send_frame(input logic [24:0] f, input int sel, input logic [8:0] tbl, input bit gap);
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        pixel_in = f[r * 5 + c];
        valid_in = 1'b1;
        if (r >= 2 && c >= 2) begin
          for (int d = 0; d < 4; d++) begin
            exp_t e;
            e.v     = (d == sel) ? tbl[(r - 2) * 3 + (c - 2)] : model(f, r, c, d);
            e.fd    = (r == 4 && c == 4);
            e.stamp = 32'(cyc + 1);
            q[d].push_back(e);
          end
        end
        if (gap) begin
          @(posedge clk); #1;
          valid_in = 1'b0;
        end
      end
    end
  endtask

  task automatic end_stream();
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    for (int d = 0; d < 4; d++) chk($sformatf("queue_empty%0d", d), 64'(q[d].size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_conv_out"}, 64'(conv_out), 64'd0);
    chk({tag, "_valid_out"}, 64'(valid_out), 64'd0);
    chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 4; d++) begin
        if (valid_out[d]) begin
          if (q[d].size() == 0) begin
            chk($sformatf("unexpected_out%0d", d), 64'd1, 64'd0);
          end else begin
            exp_t e;
            e = q[d].pop_front();
            chk($sformatf("out%0d {val,fd,cycle}", d),
                {30'd0, conv_out[d], frame_done[d], 32'(cyc)}, {30'd0, e.v, e.fd, e.stamp});
          end
          if (gap_mode) chk($sformatf("gap_b2b%0d", d), 64'(prev_v[d]), 64'd0);
        end else if (frame_done[d]) begin
          chk($sformatf("fd_without_valid%0d", d), 64'd1, 64'd0);
        end
        prev_v[d] = valid_out[d];
      end
      if (frame_done[0]) fd_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv [6];
    logic [24:0] cb;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) cb[i * 5 + j] = 1'((i + j) % 2);

    tv[0] = '{"checker",       cb,              0, 9'h0AA, 1'b0};
    tv[1] = '{"checker_gap",   cb,              0, 9'h0AA, 1'b1};
    tv[2] = '{"zero_w0_t9",    25'h0,           1, 9'h1FF, 1'b0};
    tv[3] = '{"zero_w1ff_t1",  25'h0,           2, 9'h000, 1'b0};
    tv[4] = '{"ones_t9",       25'h1FFFFFF,     3, 9'h1FF, 1'b0};
    tv[5] = '{"ones_clr00_t9", 25'h1FFFFFE,     3, 9'h1FE, 1'b0};

    repeat (3) @(posedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (tv[n]) begin
      gap_mode = tv[n].gap;
      send_frame(tv[n].frame, tv[n].sel, tv[n].exp, tv[n].gap);
      end_stream();
      drain();
    end
    gap_mode = 1'b0;

    // Two frames back-to-back: no idle cycle at the frame wrap.
    fd_cyc.delete();
    send_frame(cb, 0, 9'h0AA, 1'b0);
    send_frame(cb, 0, 9'h0AA, 1'b0);
    end_stream();
    drain();
    chk("b2b_fd_count", 64'(fd_cyc.size()), 64'd2);
    if (fd_cyc.size() == 2) chk("b2b_fd_spacing", 64'(fd_cyc[1] - fd_cyc[0]), 64'd25);

    // Abort a frame after 12 pixels; restart cleanly from (0,0).
    for (int p = 0; p < 12; p++) begin
      @(posedge clk); #1;
      pixel_in = cb[p];
      valid_in = 1'b1;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    check_reset_outputs("midreset_hold");
    @(posedge clk); #1;
    rst_n = 1'b1;
    valid_in = 1'b0;
    fd_cyc.delete();
    send_frame(cb, 0, 9'h0AA, 1'b0);
    end_stream();
    drain();
    chk("post_reset_fd_count", 64'(fd_cyc.size()), 64'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
